baud_gen: RTL and testbench
===========================

BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_DEFAULT, default 9600, meaning the baud rate in force after reset.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning receive ticks per bit; legal values are powers of two, 4 to 64.
REQ-004 The block SHALL have parameter DIV_W, default 24, meaning the divisor register width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 The block SHALL have port div_load, input, 1 bit: a one-cycle strobe that loads div_value.
REQ-008 The block SHALL have port div_value, input, DIV_W bits: the new bit period in clk cycles.
REQ-009 The block SHALL have port tx_en, input, 1 bit: transmit tick enable.
REQ-010 The block SHALL have port rx_en, input, 1 bit: receive tick enable.
REQ-011 The block SHALL have port rx_resync, input, 1 bit: restart receive phase, typically on a start-bit edge.
REQ-012 The block SHALL have port tx_tick, output, 1 bit: one-cycle pulse per bit period.
REQ-013 The block SHALL have port rx_tick, output, 1 bit: one-cycle pulse per oversample period.
REQ-014 The block SHALL have port rx_mid, output, 1 bit: one-cycle pulse at the bit-centre sample point.
REQ-015 The block SHALL have port rx_bit, output, 1 bit: one-cycle pulse at the end of each received bit.
REQ-016 The block SHALL have port div_cur, output, DIV_W bits: the divisor currently in force.

Function
REQ-017 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-018 div_reg SHALL hold the effective bit period P; a loaded value below 2*OVERSAMPLE SHALL be clamped to 2*OVERSAMPLE.
REQ-019 The receive period R SHALL be floor(P/OVERSAMPLE); the remainder SHALL be discarded.
REQ-020 The tx counter SHALL count 0..P-1 while tx_en=1; tx_tick SHALL be high exactly one cycle in every P cycles, the first P cycles after tx_en is first sampled high.
REQ-021 While tx_en=0, the tx counter SHALL be held at 0 and tx_tick SHALL be 0.
REQ-022 The rx counter SHALL count 0..R-1 while rx_en=1; rx_tick SHALL be high one cycle in every R cycles, the first R cycles after rx_en is first sampled high or after rx_resync.
REQ-023 A phase counter SHALL count rx_ticks modulo OVERSAMPLE.
REQ-024 rx_mid SHALL coincide with rx_tick number OVERSAMPLE/2 of each bit, and rx_bit with rx_tick number OVERSAMPLE, counted from 1 after enable or resync.
REQ-025 While rx_en=0, the rx and phase counters SHALL be held at 0, and rx_tick, rx_mid and rx_bit SHALL be 0.
REQ-026 When rx_resync=1, the rx and phase counters SHALL be cleared in the next cycle; all rx outputs SHALL be 0 in that cycle; tx SHALL be unaffected.
REQ-027 When div_load=1, div_reg SHALL take the clamped div_value next cycle; both counters and the phase counter SHALL clear; all tick outputs SHALL be 0 in that cycle.
REQ-028 If div_load and rx_resync are asserted together, the div_load behaviour SHALL apply; the result is identical clearing.
REQ-029 Counters SHALL never exceed their terminal count; any wrap-around SHALL return them to 0.
REQ-030 div_cur SHALL equal div_reg at all times.

Reset
REQ-031 When rst_n=0 at a rising edge, div_reg SHALL be set to CLK_FREQ/BAUD_DEFAULT (10416 at defaults, clamped per REQ-018).
REQ-032 Reset SHALL clear all counters, and tx_tick, rx_tick, rx_mid and rx_bit SHALL be 0.
REQ-033 Reset SHALL override div_load, rx_resync and the enables, including mid-period.

Verification
REQ-034 Reset, then tx_en=1, defaults -> div_cur=10416; tx_tick at cycles 10416 and 20832; rx period 651.
REQ-035 div_load with div_value=64, tx_en=rx_en=1 -> tx_tick every 64 cycles; rx_tick every 4; rx_mid on the 8th rx_tick (cycle 32); rx_bit on the 16th (cycle 64).
REQ-036 div_load with div_value=5 -> div_cur=32; R=2; tx_tick every 32 cycles.
REQ-037 Pulse rx_resync 10 cycles into a bit, P=64 -> rx outputs low that cycle; rx_mid 32 cycles after resync; tx_tick spacing unchanged.
REQ-038 Drop tx_en mid-period, then reassert -> no tx_tick while low; first tick a full P cycles after reassertion.
REQ-039 Assert rst_n=0 together with div_load=1 and value 100 -> div_cur=10416 after reset and all outputs 0.

Source files
------------

// File: rtl/baud_gen.sv
// Baud-rate tick generator: programmable bit period with a transmit tick and an
// oversampled receive tick stream that marks the bit centre and bit end.
module baud_gen #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_DEFAULT = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             tx_en,
  input  logic             rx_en,
  input  logic             rx_resync,
  output logic             tx_tick,
  output logic             rx_tick,
  output logic             rx_mid,
  output logic             rx_bit,
  output logic [DIV_W-1:0] div_cur
);

  localparam int PH_W    = $clog2(OVERSAMPLE);
  localparam int RAW_DEF = CLK_FREQ / BAUD_DEFAULT;
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2 * OVERSAMPLE);
  localparam logic [DIV_W-1:0] RST_DIV = (RAW_DEF < 2 * OVERSAMPLE) ? MIN_DIV : DIV_W'(RAW_DEF);
  localparam logic [PH_W-1:0]  MID_PH  = PH_W'(OVERSAMPLE / 2 - 1);

  // Periods shorter than two oversample periods would leave no room for a centre sample.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_tx_cnt;
  logic [DIV_W-1:0] r_rx_cnt;
  logic [PH_W-1:0]  r_phase;
  logic             r_tx_tick;
  logic             r_rx_tick;
  logic             r_rx_mid;
  logic             r_rx_bit;

  logic [DIV_W-1:0] w_rx_per;
  logic             w_tx_wrap;
  logic             w_rx_wrap;

  // OVERSAMPLE is a power of two, so the division is a shift and the remainder is dropped.
  assign w_rx_per  = r_div >> PH_W;
  assign w_tx_wrap = (r_tx_cnt >= r_div - 1'b1);
  assign w_rx_wrap = (r_rx_cnt >= w_rx_per - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div     <= RST_DIV;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_phase   <= '0;
      r_tx_tick <= 1'b0;
      r_rx_tick <= 1'b0;
      r_rx_mid  <= 1'b0;
      r_rx_bit  <= 1'b0;
    end else if (div_load) begin
      r_div     <= clamp_div(div_value);
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_phase   <= '0;
      r_tx_tick <= 1'b0;
      r_rx_tick <= 1'b0;
      r_rx_mid  <= 1'b0;
      r_rx_bit  <= 1'b0;
    end else begin
      if (!tx_en) begin
        r_tx_cnt  <= '0;
        r_tx_tick <= 1'b0;
      end else if (w_tx_wrap) begin
        r_tx_cnt  <= '0;
        r_tx_tick <= 1'b1;
      end else begin
        r_tx_cnt  <= r_tx_cnt + 1'b1;
        r_tx_tick <= 1'b0;
      end

      // The phase counter holds the number of rx ticks already issued in this bit.
      if (!rx_en || rx_resync) begin
        r_rx_cnt  <= '0;
        r_phase   <= '0;
        r_rx_tick <= 1'b0;
        r_rx_mid  <= 1'b0;
        r_rx_bit  <= 1'b0;
      end else if (w_rx_wrap) begin
        r_rx_cnt  <= '0;
        r_phase   <= r_phase + 1'b1;
        r_rx_tick <= 1'b1;
        r_rx_mid  <= (r_phase == MID_PH);
        r_rx_bit  <= (r_phase == {PH_W{1'b1}});
      end else begin
        r_rx_cnt  <= r_rx_cnt + 1'b1;
        r_rx_tick <= 1'b0;
        r_rx_mid  <= 1'b0;
        r_rx_bit  <= 1'b0;
      end
    end
  end

  assign tx_tick = r_tx_tick;
  assign rx_tick = r_rx_tick;
  assign rx_mid  = r_rx_mid;
  assign rx_bit  = r_rx_bit;
  assign div_cur = r_div;

endmodule

// File: tb/tb_baud_gen.sv
// Bench for baud_gen: directed scenarios plus randomized traffic, compared against
// an elapsed-cycle arithmetic model of the tick schedule.
module tb_baud_gen;
  localparam int CLK_FREQ = 100000000;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int DIV_W    = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             tx_en;
  logic             rx_en;
  logic             rx_resync;
  logic             tx_tick;
  logic             rx_tick;
  logic             rx_mid;
  logic             rx_bit;
  logic [DIV_W-1:0] div_cur;

  baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_DEFAULT(BAUD), .OVERSAMPLE(OS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .div_load(div_load), .div_value(div_value),
    .tx_en(tx_en), .rx_en(rx_en), .rx_resync(rx_resync),
    .tx_tick(tx_tick), .rx_tick(rx_tick), .rx_mid(rx_mid), .rx_bit(rx_bit),
    .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: current period and elapsed enabled cycles since the last restart.
  int   m_p;
  int   tx_age;
  int   rx_age;
  logic e_tx, e_rx, e_mid, e_bit;
  logic [DIV_W+3:0] exp_v;
  wire  [DIV_W+3:0] obs_v = {tx_tick, rx_tick, rx_mid, rx_bit, div_cur};

  function automatic int clampv(input int v);
    return (v < 2 * OS) ? 2 * OS : v;
  endfunction

  // Advance the model with the inputs currently applied, then clock once and settle.
  task automatic step();
    int r;
    int n;
    e_tx = 1'b0; e_rx = 1'b0; e_mid = 1'b0; e_bit = 1'b0;
    if (!rst_n) begin
      m_p = clampv(CLK_FREQ / BAUD); tx_age = 0; rx_age = 0;
    end else if (div_load) begin
      m_p = clampv(int'(div_value)); tx_age = 0; rx_age = 0;
    end else begin
      if (tx_en) begin
        tx_age++;
        e_tx = (tx_age % m_p == 0);
      end else tx_age = 0;
      if (!rx_en || rx_resync) rx_age = 0;
      else begin
        rx_age++;
        r = m_p / OS;
        if (rx_age % r == 0) begin
          n     = rx_age / r;
          e_rx  = 1'b1;
          e_mid = (n % OS == OS / 2);
          e_bit = (n % OS == 0);
        end
      end
    end
    exp_v = {e_tx, e_rx, e_mid, e_bit, DIV_W'(m_p)};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    div_load = 1'b0; rx_resync = 1'b0; div_value = '0;
  endtask

  task automatic load(input int v);
    div_load = 1'b1; div_value = DIV_W'(v);
    step();
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL load_%0d: got %h want %h", v, obs_v, exp_v);
    end
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; div_load = 1'b1; div_value = 24'd100;
    tx_en = 1'b1; rx_en = 1'b1; rx_resync = 1'b1;
    repeat (3) step();
    checks++;
    if (obs_v !== {4'b0000, 24'd10416}) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", obs_v, {4'b0000, 24'd10416});
    end
    rst_n = 1'b1; idle_inputs(); tx_en = 1'b0; rx_en = 1'b0;
    step();
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_defaults();
    int first_tx = -1, second_tx = -1, first_rx = -1;
    tx_en = 1'b1; rx_en = 1'b1;
    for (int c = 1; c <= 20832; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL defaults_c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (tx_tick && first_tx < 0) first_tx = c;
      else if (tx_tick && second_tx < 0) second_tx = c;
      if (rx_tick && first_rx < 0) first_rx = c;
    end
    checks++;
    if (first_tx != 10416 || second_tx != 20832) begin
      failures++;
      $display("FAIL defaults_tx_pos: got %0d,%0d want 10416,20832", first_tx, second_tx);
    end
    checks++;
    if (first_rx != 651) begin
      failures++;
      $display("FAIL defaults_rx_period: got %0d want 651", first_rx);
    end
  endtask

  task automatic test_div64();
    int mid_c = -1, bit_c = -1, ntx = 0, nrx = 0, last_tx = 0;
    load(64);
    for (int c = 1; c <= 128; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL div64_c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (rx_mid && mid_c < 0) mid_c = c;
      if (rx_bit && bit_c < 0) bit_c = c;
      if (tx_tick) begin ntx++; last_tx = c; end
      if (rx_tick) nrx++;
    end
    checks++;
    if (mid_c != 32 || bit_c != 64) begin
      failures++;
      $display("FAIL div64_mid_bit: got %0d,%0d want 32,64", mid_c, bit_c);
    end
    checks++;
    if (ntx != 2 || last_tx != 128 || nrx != 32) begin
      failures++;
      $display("FAIL div64_counts: got tx=%0d last=%0d rx=%0d want 2,128,32", ntx, last_tx, nrx);
    end
  endtask

  task automatic test_clamp();
    int first_rx = -1, first_tx = -1;
    load(5);
    checks++;
    if (div_cur !== 24'd32) begin
      failures++;
      $display("FAIL clamp_div_cur: got %0d want 32", div_cur);
    end
    for (int c = 1; c <= 64; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL clamp_c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (rx_tick && first_rx < 0) first_rx = c;
      if (tx_tick && first_tx < 0) first_tx = c;
    end
    checks++;
    if (first_rx != 2 || first_tx != 32) begin
      failures++;
      $display("FAIL clamp_periods: got rx=%0d tx=%0d want 2,32", first_rx, first_tx);
    end
  endtask

  task automatic test_resync();
    int mid_k = -1, tx_k = -1;
    load(64);
    repeat (10) step();
    rx_resync = 1'b1;
    step();
    checks++;
    if ({rx_tick, rx_mid, rx_bit} !== 3'b000 || obs_v !== exp_v) begin
      failures++;
      $display("FAIL resync_cycle: got %h want %h", obs_v, exp_v);
    end
    rx_resync = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL resync_k%0d: got %h want %h", k, obs_v, exp_v);
      end
      if (rx_mid && mid_k < 0) mid_k = k;
      if (tx_tick && tx_k < 0) tx_k = k;
    end
    checks++;
    if (mid_k != 32 || tx_k != 53) begin
      failures++;
      $display("FAIL resync_timing: got mid=%0d tx=%0d want 32,53", mid_k, tx_k);
    end
  endtask

  task automatic test_tx_gate();
    int seen = 0, first_k = -1;
    load(64);
    repeat (20) step();
    tx_en = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (tx_tick) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL tx_gate_low: got %0d ticks want 0", seen);
    end
    tx_en = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL tx_gate_k%0d: got %h want %h", k, obs_v, exp_v);
      end
      if (tx_tick && first_k < 0) first_k = k;
    end
    checks++;
    if (first_k != 64) begin
      failures++;
      $display("FAIL tx_gate_reassert: got %0d want 64", first_k);
    end
  endtask

  task automatic test_reset_mid();
    load(64);
    repeat (40) step();
    rst_n = 1'b0; div_load = 1'b1; div_value = 24'd100;
    step();
    checks++;
    if (obs_v !== {4'b0000, 24'd10416}) begin
      failures++;
      $display("FAIL reset_mid: got %h want %h", obs_v, {4'b0000, 24'd10416});
    end
    rst_n = 1'b1; idle_inputs();
  endtask

  task automatic test_random();
    load(int'($urandom_range(0, 200)));
    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      div_load  = ($urandom_range(0, 149) == 0);
      div_value = DIV_W'($urandom_range(0, 200));
      rx_resync = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 79) == 0) rx_en = ~rx_en;
      if (!rst_n) div_load = 1'b1;
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL random_c%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
    rst_n = 1'b1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_div64();
    test_clamp();
    test_resync();
    test_tx_gate();
    test_reset_mid();
    tx_en = 1'b1; rx_en = 1'b1;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
